// File: rtl/gcn_top.sv
// gcn_top: two-layer graph neural network over a fixed 4-node ring graph.
// Each node aggregates itself and its two ring neighbours (unweighted sum).
// Layer 1: 4 features -> 4 hidden units (4..7) with ReLU.
// Layer 2: 4 hidden units -> 2 outputs (8, 9) with no activation.
// Weights are shared by all nodes and are sampled together with the features.
// The pipeline accepts one inference per cycle. Handshake: the inputs are
// sampled on every rising edge where in_ready=1. A valid bit travels with the
// data, and all eight ready flags are high for exactly one cycle per result.
// While no result arrives, the outputs hold their last value.
// Optional macro NN_OUT_PIPE_EN adds one output register stage.
// With the macro the latency is 4 edges, without it 3 edges.
module gcn_top (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_ready,
    input  logic signed [4:0]  x0_node0, x1_node0, x2_node0, x3_node0,
    input  logic signed [4:0]  x0_node1, x1_node1, x2_node1, x3_node1,
    input  logic signed [4:0]  x0_node2, x1_node2, x2_node2, x3_node2,
    input  logic signed [4:0]  x0_node3, x1_node3, x2_node3, x3_node3,
    input  logic signed [4:0]  w04, w14, w24, w34,
    input  logic signed [4:0]  w05, w15, w25, w35,
    input  logic signed [4:0]  w06, w16, w26, w36,
    input  logic signed [4:0]  w07, w17, w27, w37,
    input  logic signed [4:0]  w48, w58, w68, w78,
    input  logic signed [4:0]  w49, w59, w69, w79,
    output logic signed [20:0] out0_node0, out0_node1, out0_node2, out0_node3,
    output logic signed [20:0] out1_node0, out1_node1, out1_node2, out1_node3,
    output logic               out10_ready_node0, out10_ready_node1,
    output logic               out10_ready_node2, out10_ready_node3,
    output logic               out11_ready_node0, out11_ready_node1,
    output logic               out11_ready_node2, out11_ready_node3
);

    // Input bundles: x_in[node][feature], w1_in[hidden][feature], w2_in[output][hidden]
    logic [3:0][3:0][4:0] x_in;
    logic [3:0][3:0][4:0] w1_in;
    logic [1:0][3:0][4:0] w2_in;

    assign x_in[0]  = {x3_node0, x2_node0, x1_node0, x0_node0};
    assign x_in[1]  = {x3_node1, x2_node1, x1_node1, x0_node1};
    assign x_in[2]  = {x3_node2, x2_node2, x1_node2, x0_node2};
    assign x_in[3]  = {x3_node3, x2_node3, x1_node3, x0_node3};
    assign w1_in[0] = {w34, w24, w14, w04};
    assign w1_in[1] = {w35, w25, w15, w05};
    assign w1_in[2] = {w36, w26, w16, w06};
    assign w1_in[3] = {w37, w27, w17, w07};
    assign w2_in[0] = {w78, w68, w58, w48};
    assign w2_in[1] = {w79, w69, w59, w49};

    // Stage 0 registers
    logic [3:0][3:0][4:0]  x_q, w1_q;
    logic [1:0][3:0][4:0]  w2_q;
    logic                  v0_q;
    // Stage 1 registers: post-ReLU hidden values h_q[node][hidden]
    logic [3:0][3:0][11:0] h_q, h_d;
    logic [1:0][3:0][4:0]  w2_s1_q;
    logic                  v1_q;
    // Stage 2 registers: out_q[output][node]
    logic [1:0][3:0][20:0] out_q, out_d;
    logic                  v2_q;

    // Combinational working values
    logic signed [12:0] agg, w1_ext, pre;
    logic signed [21:0] a_sum, w2_ext, acc;

    // Stage 0: capture features and both weight sets on every accepted sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q  <= '0;
            w1_q <= '0;
            w2_q <= '0;
            v0_q <= 1'b0;
        end else begin
            v0_q <= in_ready;
            if (in_ready) begin
                x_q  <= x_in;
                w1_q <= w1_in;
                w2_q <= w2_in;
            end
        end
    end

    // Layer 1: aggregate the ring neighbourhood, apply the weights, then clip negatives
    always_comb begin
        h_d    = '0;
        agg    = '0;
        w1_ext = '0;
        pre    = '0;
        for (int n = 0; n < 4; n++) begin
            for (int j = 0; j < 4; j++) begin
                pre = '0;
                for (int i = 0; i < 4; i++) begin
                    agg    = 13'($signed(x_q[(n + 3) % 4][i])) + 13'($signed(x_q[n][i]))
                           + 13'($signed(x_q[(n + 1) % 4][i]));
                    w1_ext = 13'($signed(w1_q[j][i]));
                    pre    = pre + agg * w1_ext;
                end
                // The pre-activation fits 13 bits, so its sign bit selects ReLU clipping
                if (!pre[12]) h_d[n][j] = pre[11:0];
            end
        end
    end

    // Stage 1: register hidden values and carry the layer-2 weights of the same sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q     <= '0;
            w2_s1_q <= '0;
            v1_q    <= 1'b0;
        end else begin
            v1_q <= v0_q;
            if (v0_q) begin
                h_q     <= h_d;
                w2_s1_q <= w2_q;
            end
        end
    end

    // Layer 2: aggregate the non-negative hidden values, then apply the signed weights
    always_comb begin
        out_d  = '0;
        a_sum  = '0;
        w2_ext = '0;
        acc    = '0;
        for (int o = 0; o < 2; o++) begin
            for (int n = 0; n < 4; n++) begin
                acc = '0;
                for (int j = 0; j < 4; j++) begin
                    a_sum  = 22'(h_q[(n + 3) % 4][j]) + 22'(h_q[n][j])
                           + 22'(h_q[(n + 1) % 4][j]);
                    w2_ext = 22'($signed(w2_s1_q[o][j]));
                    acc    = acc + a_sum * w2_ext;
                end
                out_d[o][n] = acc[20:0];
            end
        end
    end

    // Stage 2: load outputs only for valid samples, so bubbles leave the last result in place
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
            v2_q  <= 1'b0;
        end else begin
            v2_q <= v1_q;
            if (v1_q) out_q <= out_d;
        end
    end

    logic [1:0][3:0][20:0] out_fin;
    logic                  v_fin;

`ifdef NN_OUT_PIPE_EN
    logic [1:0][3:0][20:0] outp_q;
    logic                  vp_q;

    // Extra output stage: a plain one-cycle delay of values and valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outp_q <= '0;
            vp_q   <= 1'b0;
        end else begin
            outp_q <= out_q;
            vp_q   <= v2_q;
        end
    end

    assign out_fin = outp_q;
    assign v_fin   = vp_q;
`else
    assign out_fin = out_q;
    assign v_fin   = v2_q;
`endif

    assign out0_node0 = out_fin[0][0];
    assign out0_node1 = out_fin[0][1];
    assign out0_node2 = out_fin[0][2];
    assign out0_node3 = out_fin[0][3];
    assign out1_node0 = out_fin[1][0];
    assign out1_node1 = out_fin[1][1];
    assign out1_node2 = out_fin[1][2];
    assign out1_node3 = out_fin[1][3];

    assign out10_ready_node0 = v_fin;
    assign out10_ready_node1 = v_fin;
    assign out10_ready_node2 = v_fin;
    assign out10_ready_node3 = v_fin;
    assign out11_ready_node0 = v_fin;
    assign out11_ready_node1 = v_fin;
    assign out11_ready_node2 = v_fin;
    assign out11_ready_node3 = v_fin;

endmodule

// File: tb/tb_gcn_top.sv
// Directed testbench for gcn_top. The expected values are hand-computed from the
// ring-graph GNN equations. The latency follows NN_OUT_PIPE_EN.
module tb_gcn_top;

`ifdef NN_OUT_PIPE_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  logic in_ready;
  always #5 clk = ~clk;

  logic signed [4:0] x [4][4];   // [node][feature]
  logic signed [4:0] w1 [4][4];  // [hidden 4..7][feature]
  logic signed [4:0] w2 [2][4];  // [output 8..9][hidden 4..7]

  logic signed [20:0] o0 [4];
  logic signed [20:0] o1 [4];
  logic r10 [4];
  logic r11 [4];
  logic [7:0] rdy;

  int n_checks = 0;
  int n_fail = 0;

  gcn_top dut (
    .clk(clk), .rst_n(rst_n), .in_ready(in_ready),
    .x0_node0(x[0][0]), .x1_node0(x[0][1]), .x2_node0(x[0][2]), .x3_node0(x[0][3]),
    .x0_node1(x[1][0]), .x1_node1(x[1][1]), .x2_node1(x[1][2]), .x3_node1(x[1][3]),
    .x0_node2(x[2][0]), .x1_node2(x[2][1]), .x2_node2(x[2][2]), .x3_node2(x[2][3]),
    .x0_node3(x[3][0]), .x1_node3(x[3][1]), .x2_node3(x[3][2]), .x3_node3(x[3][3]),
    .w04(w1[0][0]), .w14(w1[0][1]), .w24(w1[0][2]), .w34(w1[0][3]),
    .w05(w1[1][0]), .w15(w1[1][1]), .w25(w1[1][2]), .w35(w1[1][3]),
    .w06(w1[2][0]), .w16(w1[2][1]), .w26(w1[2][2]), .w36(w1[2][3]),
    .w07(w1[3][0]), .w17(w1[3][1]), .w27(w1[3][2]), .w37(w1[3][3]),
    .w48(w2[0][0]), .w58(w2[0][1]), .w68(w2[0][2]), .w78(w2[0][3]),
    .w49(w2[1][0]), .w59(w2[1][1]), .w69(w2[1][2]), .w79(w2[1][3]),
    .out0_node0(o0[0]), .out0_node1(o0[1]), .out0_node2(o0[2]), .out0_node3(o0[3]),
    .out1_node0(o1[0]), .out1_node1(o1[1]), .out1_node2(o1[2]), .out1_node3(o1[3]),
    .out10_ready_node0(r10[0]), .out10_ready_node1(r10[1]),
    .out10_ready_node2(r10[2]), .out10_ready_node3(r10[3]),
    .out11_ready_node0(r11[0]), .out11_ready_node1(r11[1]),
    .out11_ready_node2(r11[2]), .out11_ready_node3(r11[3])
  );

  assign rdy = {r11[3], r11[2], r11[1], r11[0], r10[3], r10[2], r10[1], r10[0]};

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input int v);
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        x[a][b]  = 5'(v);
        w1[a][b] = 5'(v);
      end
      w2[0][a] = 5'(v);
      w2[1][a] = 5'(v);
    end
  endtask

  task automatic set_mixed();
    x[0] = '{5'sd4, 5'sd2, 5'sd4, 5'sd1};
    x[1] = '{5'sd6, 5'sd4, 5'sd4, 5'sd1};
    x[2] = '{5'sd8, 5'sd6, 5'sd4, 5'sd1};
    x[3] = '{5'sd6, 5'sd4, 5'sd4, 5'sd1};
    w1[0] = '{5'sd3, 5'sd2, 5'sd13, -5'sd6};
    w1[1] = '{-5'sd9, 5'sd1, -5'sd4, 5'sd14};
    w1[2] = '{5'sd3, 5'sd6, -5'sd15, 5'sd15};
    w1[3] = '{5'sd9, -5'sd10, 5'sd15, -5'sd10};
    w2[0] = '{5'sd0, -5'sd1, 5'sd3, -5'sd11};
    w2[1] = '{-5'sd12, -5'sd15, -5'sd15, 5'sd6};
  endtask

  // scoreboard checks
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d, expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic check_ready(input string tag, input logic [7:0] exp);
    n_checks++;
    assert (rdy === exp) else begin
      n_fail++;
      $error("FAIL %s: ready got %b, expected %b", tag, rdy, exp);
    end
  endtask

  task automatic check_outs(input string tag,
                            input int a0, input int a1, input int a2, input int a3,
                            input int b0, input int b1, input int b2, input int b3);
    int ea [4];
    int eb [4];
    ea = '{a0, a1, a2, a3};
    eb = '{b0, b1, b2, b3};
    for (int n = 0; n < 4; n++) begin
      chk($sformatf("%s out0_node%0d", tag, n), 32'(o0[n]), 32'(ea[n]));
      chk($sformatf("%s out1_node%0d", tag, n), 32'(o1[n]), 32'(eb[n]));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_ready = 1'b0;
    set_all(0);
    repeat (2) tick();

    // reset state
    check_ready("reset", 8'h00);
    check_outs("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();
    check_ready("idle_after_reset", 8'h00);

    // mixed vector, in_ready held
    set_mixed();
    in_ready = 1'b1;
    repeat (LAT) tick();
    check_ready("mixed", 8'hFF);
    check_outs("mixed", -6358, -6309, -6287, -6309, -4188, -4455, -4587, -4455);

    // back-to-back samples: all -16, then all 15, then a bubble
    set_all(-16);
    tick();
    set_all(15);
    tick();
    in_ready = 1'b0;
    set_all(0);
    tick();
    repeat (LAT - 3) tick();
    check_ready("neg16", 8'hFF);
    check_outs("neg16", -589824, -589824, -589824, -589824,
               -589824, -589824, -589824, -589824);
    tick();
    check_ready("pos15", 8'hFF);
    check_outs("pos15", 486000, 486000, 486000, 486000, 486000, 486000, 486000, 486000);
    tick();
    check_ready("bubble", 8'h00);
    check_outs("bubble_hold", 486000, 486000, 486000, 486000,
               486000, 486000, 486000, 486000);

    // single pulse with the ReLU-probe weights (w58 = w68 = 1)
    set_mixed();
    w2[0][1] = 5'sd1;
    w2[0][2] = 5'sd1;
    in_ready = 1'b1;
    tick();
    in_ready = 1'b0;
    set_all(0);
    repeat (LAT - 2) tick();
    check_ready("pulse_early", 8'h00);
    check_outs("pulse_early_hold", 486000, 486000, 486000, 486000,
               486000, 486000, 486000, 486000);
    tick();
    check_ready("pulse", 8'hFF);
    check_outs("relu", -6358, -6327, -6305, -6327, -4188, -4455, -4587, -4455);
    tick();
    check_ready("pulse_after", 8'h00);
    check_outs("relu_hold", -6358, -6327, -6305, -6327, -4188, -4455, -4587, -4455);

    // reset one cycle after sampling
    set_mixed();
    in_ready = 1'b1;
    tick();
    in_ready = 1'b0;
    set_all(0);
    tick();
    rst_n = 1'b0;
    #1;
    check_ready("async_reset", 8'h00);
    check_outs("async_reset", 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < LAT + 1; k++) begin
      tick();
      check_ready($sformatf("no_stale_%0d", k), 8'h00);
      chk($sformatf("no_stale_%0d out0_node0", k), 32'(o0[0]), 32'd0);
    end

    // first sample after reset release
    set_all(15);
    in_ready = 1'b1;
    tick();
    in_ready = 1'b0;
    set_all(0);
    repeat (LAT - 1) tick();
    check_ready("post_reset", 8'hFF);
    check_outs("post_reset", 486000, 486000, 486000, 486000,
               486000, 486000, 486000, 486000);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gcn_top.md
Name: gcn_top

Overview:
- Two-layer graph neural network over a fixed 4-node ring graph (node k adjacent to k-1 and k+1 mod 4, plus a self loop).
- Each node has 4 signed feature inputs. Layer 1 maps 4 features to 4 hidden units (units 4..7), with neighbourhood aggregation and ReLU.
- Layer 2 maps the 4 hidden units to 2 outputs (units 8, 9), with aggregation and no activation.
- Top-level inference block. Weights are shared by all nodes. Fully pipelined, one inference per cycle.

Parameters:
- None. Widths are fixed: input 5b signed, hidden 13b signed pre-ReLU, output 21b signed.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_ready  input  1  inputs are valid this cycle and are sampled
- x0_node0..x3_node3  input  5 each  feature i of node n (xi_noden), two's complement, 16 ports
- w04..w34, w05..w35, w06..w36, w07..w37  input  5 each  layer-1 weight from feature i to hidden j (wij), signed
- w48..w78, w49..w79  input  5 each  layer-2 weight from hidden j to output o (wjo), signed
- out0_node0..out0_node3  output  21  output unit 8 for node n, signed
- out1_node0..out1_node3  output  21  output unit 9 for node n, signed
- out10_ready_node0..3  output  1  out0_noden valid
- out11_ready_node0..3  output  1  out1_noden valid

Behaviour:
- Neighbourhood: N(n) = {n-1, n, n+1} mod 4, unweighted sum.
- Layer 1:
  - agg_i(n) = sum over m in N(n) of x_i(m).
  - h_j(n) = ReLU( sum over i=0..3 of agg_i(n) * w_ij ), for j = 4..7.
  - Pre-ReLU range is -2880..3072, so 13b signed; post-ReLU is 12b unsigned.
- Layer 2:
  - a_j(n) = sum over m in N(n) of h_j(m).
  - out_o(n) = sum over j=4..7 of a_j(n) * w_jo, for o = 8, 9.
  - No ReLU. Range is -589824..552960, sign-extended into 21b.
- All arithmetic is exact signed arithmetic. There is no overflow or saturation at any legal input.
- Pipeline, with edge E being a rising edge where in_ready=1:
  - Stage 0 at E: register all x and w.
  - Stage 1 at E+1: register aggregated ReLU hidden values for all 4 nodes.
  - Stage 2 at E+2: register outputs and set ready flags.
  - Latency is 3 rising edges from the sampling edge to the output update.
- in_ready=1 on consecutive cycles gives one result per cycle.
- A valid bit travels with the data. All 8 ready flags equal the stage-2 valid bit.
- When a bubble (in_ready=0) reaches the output, ready flags go to 0 and outputs hold their last value.
- Weights are sampled together with features. A weight change with in_ready=1 takes effect for that sample.
- Reset (asynchronous, any time including mid-pipeline): all pipeline registers, outputs and ready flags clear to 0 immediately.
- Results of in-flight samples are discarded on reset. The first valid result comes 3 edges after the first in_ready=1 edge following reset release.

Optional Feature:
- Macro NN_OUT_PIPE_EN.
- When defined: an extra register follows stage 2. Outputs and ready flags are delayed by one cycle, giving 4-edge latency. Values are unchanged.
- When undefined: 3-edge latency as specified.

Test Plan:
- Mixed vector, in_ready=1 held:
  - Features: node0=(4,2,4,1), node1=(6,4,4,1), node2=(8,6,4,1), node3=(6,4,4,1).
  - w04..w34=(3,2,13,-6), w05..w35=(-9,1,-4,14), w06..w36=(3,6,-15,15), w07..w37=(9,-10,15,-10).
  - w48..w78=(0,-1,3,-11), w49..w79=(-12,-15,-15,6).
  - Required out0/out1: node0 = -6358/-4188; node1 = -6309/-4455; node2 = -6287/-4587; node3 = -6309/-4455.
- All x and w = -16 -> every output = -589824; ready=1.
- All x and w = 15 -> every output = 486000.
- Latency/bubble:
  - Single in_ready=1 pulse -> ready flags high for exactly 1 cycle, 3 edges later.
  - Outputs hold their value afterwards while ready=0.
- Reset mid-pipeline: assert rst_n=0 one cycle after sampling -> outputs=0 and ready=0 immediately; no stale result after release.
- ReLU check:
  - node0 hidden pre-activations are (206,-140,-27,194); units 5 and 6 must clip to 0.
  - Use the mixed vector but with w58=w68=1 -> out0_node0 must stay -6358 minus the contributions of hidden units 5 and 6, which are 0.
